// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter sharing one adder_tree among NUM_REQ requesters.
// Issues at most one product vector per cycle, limits outstanding vectors with
// a credit counter, and routes each returned sum to its issuer via a tag FIFO.
module adder_tree_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned CREDITS      = 8,
    localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_WIDTH,
    localparam int unsigned VEC_W  = PROD_W * KERNEL_SIZE,
    localparam int unsigned RES_W  = PROD_W + $clog2(KERNEL_SIZE),
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CNT_W  = $clog2(CREDITS + 1),
    localparam int unsigned PTR_W  = (CREDITS > 1) ? $clog2(CREDITS) : 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*VEC_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       adder_en,
    output logic [VEC_W-1:0]           adder_dataIn,
    input  logic                       res_tvalid,
    input  logic [RES_W-1:0]           res_tdata,
    output logic                       res_tready,
    output logic [NUM_REQ-1:0]         out_tvalid,
    output logic [RES_W-1:0]           out_tdata,
    input  logic [NUM_REQ-1:0]         out_tready,
    output logic [CNT_W-1:0]           in_flight,
    output logic                       busy,
    output logic                       err_no_tag
);

    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   in_flight_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [ID_W-1:0]    tag_mem [CREDITS];
    logic               adder_en_q;
    logic [VEC_W-1:0]   adder_data_q;
    logic               err_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_found;
    logic               issue;
    logic               ret;
    logic               tag_v;
    logic [ID_W-1:0]    head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CREDITS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting after the last granted requester, gated by credits.
    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        grant       = '0;
        if (in_flight_q < CNT_W'(CREDITS)) begin
            for (int k = 1; k <= int'(NUM_REQ); k++) begin
                if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % int'(NUM_REQ)]) begin
                    grant_found = 1'b1;
                    grant_id    = ID_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
                end
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            grant[i] = grant_found && (grant_id == ID_W'(i));
        end
    end

    assign req_ready = grant;
    assign issue     = |(req_valid & grant);

    assign tag_v = (in_flight_q != '0);
    assign head  = tag_mem[rd_ptr_q];

    // Steer the shared result to the requester named by the oldest tag.
    always_comb begin
        out_tvalid = '0;
        res_tready = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (tag_v && (head == ID_W'(i))) begin
                out_tvalid[i] = res_tvalid;
                res_tready    = out_tready[i];
            end
        end
    end

    assign out_tdata = res_tdata;
    assign ret       = res_tvalid & res_tready;

    // Tag storage; contents are only read while in_flight is non-zero, so no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr_q] <= grant_id;
        end
    end

    // Arbitration pointer, issue register, tag pointers, credit count and error flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q     <= ID_W'(NUM_REQ - 1);
            in_flight_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            adder_en_q   <= 1'b0;
            adder_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            adder_en_q <= issue;
            if (issue) begin
                rr_ptr_q     <= grant_id;
                adder_data_q <= req_data[int'(grant_id) * VEC_W +: VEC_W];
                wr_ptr_q     <= ptr_inc(wr_ptr_q);
            end
            if (ret) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            // The tag count equals in_flight, so it doubles as the FIFO occupancy.
            if (issue && !ret) begin
                in_flight_q <= in_flight_q + 1'b1;
            end else if (!issue && ret) begin
                in_flight_q <= in_flight_q - 1'b1;
            end
            if (res_tvalid && !tag_v) begin
                err_q <= 1'b1;
            end
        end
    end

    assign adder_en     = adder_en_q;
    assign adder_dataIn = adder_data_q;
    assign in_flight    = in_flight_q;
    assign busy         = tag_v;
    assign err_no_tag   = err_q;

endmodule
